// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host frame receiver.
// Covers frame geometry, FSM states, error codes and the odd-parity rule.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    LOAD = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_STOP    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int FRAME_BITS = 11;
  // Everything after the start bit: 8 data, parity, stop.
  localparam int SHIFT_BITS = FRAME_BITS - 1;

  // Odd parity over data plus parity bit: the XOR of all nine must be 1.
  function automatic logic parity_ok(input logic [SHIFT_BITS-2:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the raw PS/2 pins, debounces ps2c with a FILTER_LEN-sample
// window and emits a one-cycle pulse on each filtered falling edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall,
  output logic ps2d_s
);

  logic [1:0]            c_sync_q, c_sync_d;
  logic [1:0]            d_sync_q, d_sync_d;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  f_ps2c_q, f_ps2c_d;
  logic                  f_prev_q, f_prev_d;

  // NOTE: combinational processes use blocking '=' and assign every output a
  // default first, so no path leaves a signal unassigned and infers a latch.
  always_comb begin
    c_sync_d = {c_sync_q[0], ps2c};
    d_sync_d = {d_sync_q[0], ps2d};
    filt_d   = {filt_q[FILTER_LEN-2:0], c_sync_q[1]};
    f_prev_d = f_ps2c_q;
    f_ps2c_d = f_ps2c_q;
    if (&filt_q)       f_ps2c_d = 1'b1;
    else if (~|filt_q) f_ps2c_d = 1'b0;
  end

  // Reset to the idle-high line level so release never fakes a falling edge.
  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      filt_q   <= '1;
      f_ps2c_q <= 1'b1;
      f_prev_q <= 1'b1;
    end else begin
      c_sync_q <= c_sync_d;
      d_sync_q <= d_sync_d;
      filt_q   <= filt_d;
      f_ps2c_q <= f_ps2c_d;
      f_prev_q <= f_prev_d;
    end
  end

  assign fall   = f_prev_q & ~f_ps2c_q;
  assign ps2d_s = d_sync_q[1];

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: assembles 11-bit frames on filtered
// clock falls, checks start/parity/stop and flags inter-edge timeouts.
import ps2_pkg::*;

module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       err_tick,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic fall;
  logic ps2d_s;

  state_e                state_q, state_d;
  logic [3:0]            n_q, n_d;
  logic [SHIFT_BITS-1:0] b_q, b_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [7:0]            dout_q, dout_d;
  logic [1:0]            err_code_q, err_code_d;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk    (clk),
    .reset  (reset),
    .ps2c   (ps2c),
    .ps2d   (ps2d),
    .fall   (fall),
    .ps2d_s (ps2d_s)
  );

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    b_d          = b_q;
    tmo_d        = tmo_q;
    dout_d       = dout_q;
    err_code_d   = err_code_q;
    rx_done_tick = 1'b0;
    err_tick     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall && rx_en && !ps2d_s) begin
          n_d     = 4'd9;
          tmo_d   = '0;
          state_d = DPS;
        end
      end

      DPS: begin
        if (fall) begin
          b_d   = {ps2d_s, b_q[SHIFT_BITS-1:1]};
          tmo_d = '0;
          if (n_q == 4'd0) state_d = LOAD;
          else             n_d     = n_q - 4'd1;
        end else if (tmo_q == TMO_LAST) begin
          // Counter stops here; the abort is the only way out of the stall.
          err_tick   = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      LOAD: begin
        state_d = IDLE;
        if (!b_q[SHIFT_BITS-1]) begin
          err_tick   = 1'b1;
          err_code_d = ERR_STOP;
        end else if (!parity_ok(b_q[SHIFT_BITS-2:0])) begin
          err_tick   = 1'b1;
          err_code_d = ERR_PARITY;
        end else begin
          dout_d       = b_q[7:0];
          rx_done_tick = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      b_q        <= '0;
      tmo_q      <= '0;
      dout_q     <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      b_q        <= b_d;
      tmo_q      <= tmo_d;
      dout_q     <= dout_d;
      err_code_q <= err_code_d;
    end
  end

  // Present next-state values so dout/err_code change in the same cycle as the tick.
  assign dout     = dout_d;
  assign err_code = err_code_d;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: frame-level reference model (queue of
// expected outcomes) compared against the DUT on every clock.
module tb_ps2_frame_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 200;
  localparam int HALF       = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2d;
  logic       ps2c;
  logic       rx_en;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       err_tick;
  logic [1:0] err_code;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic [1:0] code;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_dout;
  logic [1:0] model_code;
  bit         expect_idle;
  int         checks;
  int         errors;

  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2d         (ps2d),
    .ps2c         (ps2c),
    .rx_en        (rx_en),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .err_tick     (err_tick),
    .err_code     (err_code),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Outcome of a complete frame, straight from the start/parity/stop rules.
  task automatic expect_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop);
    ev_t e;
    e.data   = data;
    e.is_err = bad_par | bad_stop;
    e.code   = bad_stop ? 2'b10 : (bad_par ? 2'b01 : 2'b00);
    exp_q.push_back(e);
  endtask

  task automatic expect_timeout();
    ev_t e;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    e.code   = 2'b11;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic v, input bit glitch);
    ps2d = v;
    if (glitch) begin
      wait_cycles(12);
      ps2c = 1'b0;
      wait_cycles(3);
      ps2c = 1'b1;
      wait_cycles(HALF - 15);
    end else begin
      wait_cycles(HALF);
    end
    ps2c = 1'b0;
    wait_cycles(HALF);
    ps2c = 1'b1;
  endtask

  // Sends the first nbits of an 11-bit frame, start bit first, data LSB first.
  task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                            input bit glitch, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], glitch);
    ps2d = 1'b1;
  endtask

  task automatic full_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                            input bit glitch, input int gap);
    expect_frame(data, bad_par, bad_stop);
    send_frame(data, bad_par, bad_stop, glitch, 11);
    wait_cycles(gap);
    check("frame_outcome_delivered", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      model_dout <= 8'h00;
      model_code <= 2'b00;
    end else begin
      if (rx_done_tick || err_tick) begin
        check("tick_exclusive", 32'(rx_done_tick & err_tick), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_tick", {30'b0, rx_done_tick, err_tick}, 0);
        end else begin
          check("tick_kind", 32'(err_tick), 32'(exp_q[0].is_err));
          if (exp_q[0].is_err) begin
            check("err_code", 32'(err_code), 32'(exp_q[0].code));
            check("dout_kept", 32'(dout), 32'(model_dout));
            model_code <= exp_q[0].code;
          end else begin
            check("dout", 32'(dout), 32'(exp_q[0].data));
            check("err_code_kept", 32'(err_code), 32'(model_code));
            model_dout <= exp_q[0].data;
          end
          void'(exp_q.pop_front());
        end
      end else begin
        check("hold", {22'b0, dout, err_code}, {22'b0, model_dout, model_code});
      end
      if (expect_idle) check("busy_idle", 32'(busy), 0);
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    expect_idle = 1'b0;
    reset       = 1'b1;
    ps2c        = 1'b1;
    ps2d        = 1'b1;
    rx_en       = 1'b1;
    wait_cycles(5);
    check("reset_dout", 32'(dout), 0);
    check("reset_ticks", {30'b0, rx_done_tick, err_tick}, 0);
    check("reset_err_code", 32'(err_code), 0);
    check("reset_busy", 32'(busy), 0);
    reset = 1'b0;
    wait_cycles(20);

    full_frame(8'h1C, 1'b0, 1'b0, 1'b0, 30);
    check("lit_dout_1c", 32'(dout), 32'h1C);

    full_frame(8'hF0, 1'b1, 1'b0, 1'b0, 30);
    check("lit_parity_code", 32'(err_code), 32'h1);
    check("lit_dout_kept_1c", 32'(dout), 32'h1C);

    full_frame(8'hF0, 1'b0, 1'b0, 1'b0, 30);
    check("lit_dout_f0", 32'(dout), 32'hF0);

    full_frame(8'h1C, 1'b1, 1'b1, 1'b0, 30);
    check("lit_stop_code", 32'(err_code), 32'h2);

    expect_timeout();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 5);
    wait_cycles(TIMEOUT + 20);
    check("lit_timeout_code", 32'(err_code), 32'h3);
    check("timeout_busy", 32'(busy), 0);
    check("timeout_delivered", exp_q.size(), 0);
    full_frame(8'h29, 1'b0, 1'b0, 1'b0, 30);
    check("lit_dout_29", 32'(dout), 32'h29);

    full_frame(8'h5A, 1'b0, 1'b0, 1'b1, 30);
    check("lit_dout_5a", 32'(dout), 32'h5A);

    rx_en       = 1'b0;
    expect_idle = 1'b1;
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 11);
    wait_cycles(30);
    expect_idle = 1'b0;
    rx_en       = 1'b1;
    check("lit_disabled_dout", 32'(dout), 32'h5A);

    expect_frame(8'hA7, 1'b0, 1'b0);
    send_frame(8'hA7, 1'b0, 1'b0, 1'b0, 6);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_dout", 32'(dout), 0);
    check("midreset_ticks", {30'b0, rx_done_tick, err_tick}, 0);
    check("midreset_err_code", 32'(err_code), 0);
    check("midreset_busy", 32'(busy), 0);
    wait_cycles(4);
    reset = 1'b0;
    wait_cycles(30);
    full_frame(8'h1C, 1'b0, 1'b0, 1'b0, 30);
    check("lit_dout_after_reset", 32'(dout), 32'h1C);

    for (int k = 0; k < 25; k++) begin
      logic [7:0] data;
      int         kind;
      bit         glitch;
      int         gap;
      data   = 8'($urandom);
      kind   = $urandom_range(0, 9);
      glitch = 1'($urandom_range(0, 1));
      gap    = $urandom_range(0, 30);
      if (kind == 2) begin
        rx_en       = 1'b0;
        expect_idle = 1'b1;
        send_frame(data, 1'b0, 1'b0, glitch, 11);
        wait_cycles(gap);
        expect_idle = 1'b0;
        rx_en       = 1'b1;
      end else begin
        full_frame(data, kind == 0, kind == 1, glitch, gap);
      end
    end

    wait_cycles(50);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
